// File: rtl/mtm_alu_deserializer_if.sv
// mtm_alu_deserializer_if: serial input line and decoded operand/error outputs of the receive stage
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  OP;
  logic        data_valid;
  logic        err_valid;
  logic [7:0]  err_ctl;
  modport master (input sin, output A, B, OP, data_valid, err_valid, err_ctl);
  modport slave (output sin, input A, B, OP, data_valid, err_valid, err_ctl);
endinterface

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: recovers 8 data + 1 ctl frame packets from sin and strobes A/B/OP or an error byte
module mtm_alu_deserializer #(
  parameter int DATA_FRAMES = 8,
  parameter int CRC_W = 4
) (
  input logic clk,
  input logic rst,
  mtm_alu_deserializer_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, TYPE = 3'd1, DATA = 3'd2, STOP = 3'd3, CHECK = 3'd4, ERR = 3'd5, FLUSH = 3'd6;
  localparam logic [7:0] ERR_DATA = 8'b11001001, ERR_OP = 8'b10010011, ERR_CRC = 8'b10100101;
  logic [2:0] state_q, state_d;
  logic type_q, type_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [63:0] data_q, data_d;
  logic [3:0] data_cnt_q, data_cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [7:0] err_q, err_d;
  logic dv_q, dv_d, ev_q, ev_d;
  logic bad_data, bad_crc, bad_op;
  // MSB-first x^4+x+1 LFSR, zero init
  function automatic logic [CRC_W-1:0] crc4(input logic [67:0] v);
    logic [CRC_W-1:0] c;
    c = '0;
    for (int i = 67; i >= 0; i--)
      c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ v[i]) ? CRC_W'(4'b0011) : '0);
    return c;
  endfunction
  // In CHECK, sh_q still holds the ctl payload {0, OP, CRC}
  assign bad_data = (data_cnt_q != 4'(DATA_FRAMES)) || sh_q[7];
  assign bad_crc = sh_q[CRC_W-1:0] != crc4({data_q, 1'b1, sh_q[6:4]});
  assign bad_op = !(sh_q[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    bit_cnt_d = bit_cnt_q;
    sh_d = sh_q;
    data_d = data_q;
    data_cnt_d = data_cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    err_d = err_q;
    dv_d = 1'b0;
    ev_d = 1'b0;
    case (state_q)
      IDLE: state_d = bus.sin ? IDLE : TYPE;
      TYPE: begin
        type_d = bus.sin;
        bit_cnt_d = 3'd7;
        state_d = DATA;
      end
      DATA: begin
        sh_d = {sh_q[6:0], bus.sin};
        bit_cnt_d = bit_cnt_q - 3'd1;
        state_d = (bit_cnt_q == 3'd0) ? STOP : DATA;
      end
      STOP: begin
        if (!bus.sin || (!type_q && data_cnt_q == 4'(DATA_FRAMES))) state_d = ERR;
        else if (type_q) state_d = CHECK;
        else begin
          data_d = {data_q[55:0], sh_q};
          data_cnt_d = data_cnt_q + 4'd1;
          state_d = IDLE;
        end
      end
      CHECK: begin
        dv_d = !(bad_data || bad_crc || bad_op);
        ev_d = !dv_d;
        err_d = bad_data ? ERR_DATA : bad_crc ? ERR_CRC : bad_op ? ERR_OP : err_q;
        {b_d, a_d} = dv_d ? data_q : {b_q, a_q};
        op_d = dv_d ? sh_q[6:4] : op_q;
        data_d = '0;
        data_cnt_d = '0;
        state_d = bus.sin ? IDLE : TYPE;
      end
      ERR: begin
        ev_d = 1'b1;
        err_d = ERR_DATA;
        data_d = '0;
        data_cnt_d = '0;
        state_d = FLUSH;
      end
      FLUSH: state_d = bus.sin ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q <= 1'b0;
      bit_cnt_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      data_cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      err_q <= '0;
      dv_q <= 1'b0;
      ev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q <= sh_d;
      data_q <= data_d;
      data_cnt_q <= data_cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      err_q <= err_d;
      dv_q <= dv_d;
      ev_q <= ev_d;
    end
  end
  assign bus.A = a_q;
  assign bus.B = b_q;
  assign bus.OP = op_q;
  assign bus.data_valid = dv_q;
  assign bus.err_valid = ev_q;
  assign bus.err_ctl = err_q;
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed packets with a scoreboard of expected strobes
module tb_mtm_alu_deserializer;
  localparam logic [7:0] ERR_DATA = 8'b11001001, ERR_OP = 8'b10010011, ERR_CRC = 8'b10100101;
  typedef struct {
    logic        err;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [7:0]  ec;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int t0;
  exp_t sbq[$];
  exp_t e;
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0;
  logic [7:0] m_err = '0;
  mtm_alu_deserializer_if bus();
  mtm_alu_deserializer #(.DATA_FRAMES(8), .CRC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Reference CRC as polynomial division of v*x^4 by x^4+x+1
  function automatic logic [3:0] crc_ref(input logic [67:0] v);
    logic [71:0] r;
    r = {v, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    return r[3:0];
  endfunction
  task automatic exp_good(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    m_a = a;
    m_b = b;
    m_op = op;
    sbq.push_back('{1'b0, m_a, m_b, m_op, m_err});
  endtask
  task automatic exp_err(input logic [7:0] ec);
    m_err = ec;
    sbq.push_back('{1'b1, m_a, m_b, m_op, m_err});
  endtask
  task automatic send_bit(input logic b);
    bus.sin = b;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask
  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask
  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic [3:0] cx, input int nd);
    logic [63:0] ba;
    ba = {b, a};
    for (int i = 0; i < nd; i++) send_frame(1'b0, ba[63-8*i -: 8], 1'b1);
    send_frame(1'b1, {1'b0, op, crc_ref({b, a, 1'b1, op}) ^ cx}, 1'b1);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d strobes missing, expected 0", sbq.size());
      sbq.delete();
    end
    idle(4);
  endtask
  always @(negedge clk) begin
    if (!rst && (bus.data_valid || bus.err_valid)) begin
      last_cyc = cyc;
      chk("exclusive", 64'(bus.data_valid & bus.err_valid), 64'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: dv=%0b ev=%0b expected none", bus.data_valid, bus.err_valid);
      end else begin
        e = sbq.pop_front();
        chk("kind_err_valid", 64'(bus.err_valid), 64'(e.err));
        chk("A", 64'(bus.A), 64'(e.a));
        chk("B", 64'(bus.B), 64'(e.b));
        chk("OP", 64'(bus.OP), 64'(e.op));
        chk("err_ctl", 64'(bus.err_ctl), 64'(e.ec));
      end
    end
  end
  initial begin
    bus.sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_A", 64'(bus.A), 64'd0);
    chk("rst_B", 64'(bus.B), 64'd0);
    chk("rst_OP", 64'(bus.OP), 64'd0);
    chk("rst_dv", 64'(bus.data_valid), 64'd0);
    chk("rst_ev", 64'(bus.err_valid), 64'd0);
    chk("rst_err_ctl", 64'(bus.err_ctl), 64'd0);
    idle(3);
    exp_good(32'h1, 32'h2, 3'b100);
    t0 = cyc;
    send_pkt(32'h2, 32'h1, 3'b100, 4'h0, 8);
    drain();
    chk("good_latency", 64'(last_cyc - t0), 64'd100);
    exp_err(ERR_CRC);
    send_pkt(32'h2, 32'h1, 3'b100, 4'h1, 8);
    drain();
    exp_err(ERR_OP);
    send_pkt(32'h5, 32'h6, 3'b111, 4'h0, 8);
    drain();
    exp_err(ERR_DATA);
    send_pkt(32'h9, 32'h9, 3'b000, 4'h0, 7);
    drain();
    exp_good(32'h3, 32'h7, 3'b000);
    send_pkt(32'h7, 32'h3, 3'b000, 4'h0, 8);
    drain();
    exp_err(ERR_DATA);
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    t0 = cyc;
    send_frame(1'b0, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    idle(2);
    chk("framing_latency", 64'(last_cyc - t0), 64'd12);
    drain();
    exp_good(32'h12345678, 32'hDEADBEEF, 3'b001);
    send_pkt(32'hDEADBEEF, 32'h12345678, 3'b001, 4'h0, 8);
    drain();
    exp_err(ERR_DATA);
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'(i + 1), 1'b1);
    idle(3);
    drain();
    exp_good(32'h0F0F0F0F, 32'hAAAA5555, 3'b101);
    exp_good(32'h2, 32'h1, 3'b100);
    send_pkt(32'hAAAA5555, 32'h0F0F0F0F, 3'b101, 4'h0, 8);
    send_pkt(32'h1, 32'h2, 3'b100, 4'h0, 8);
    drain();
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hA5, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bus.sin = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_a = '0;
    m_b = '0;
    m_op = '0;
    m_err = '0;
    chk("midrst_A", 64'(bus.A), 64'd0);
    chk("midrst_err_ctl", 64'(bus.err_ctl), 64'd0);
    idle(3);
    exp_good(32'hFFFFFFFF, 32'h1, 3'b101);
    send_pkt(32'h1, 32'hFFFFFFFF, 3'b101, 4'h0, 8);
    drain();
    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
